// File: rtl/cpu6502_core.sv
// cpu6502_core: a tiny 6502-flavoured core. It runs one bus cycle per clock
// and supports LDA #, ADC #, NOP, CLC, SEC, LDA abs, STA abs and JMP abs.
// Any other opcode parks the core in HALT until reset.
// Ports:
//   clk    - single clock; all state changes on its rising edge
//   reset  - asynchronous, active-high reset
//   addr   - registered bus address (ADDR_WIDTH bits)
//   data   - tri-state 8-bit data bus; the core drives it only while rw=0
//   rw     - registered bus direction, 1=read, 0=write
//   halted - high while the core sits in HALT
//   acc    - accumulator, debug view
//   flags  - {N,Z,C}, debug view
module cpu6502_core #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [7:0]            data,
    output logic                  rw,
    output logic                  halted,
    output logic [7:0]            acc,
    output logic [2:0]            flags
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        ADDR_HI = 3'd2,
        MEM_RD  = 3'd3,
        MEM_WR  = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] pc_r, pc_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic                  rw_r, rw_s;
    logic [7:0]            a_r, a_s;
    logic                  n_r, n_s, z_r, z_s, c_r, c_s;
    logic [7:0]            ir_r, ir_s;
    logic [7:0]            adl_r, adl_s;
    logic [7:0]            wdata_r, wdata_s;

    logic [ADDR_WIDTH-1:0] pc_inc_s;
    logic [15:0]           abs_full_s;
    logic [ADDR_WIDTH-1:0] abs_s;
    logic [8:0]            sum_s;

    // {N,Z} for a freshly loaded accumulator value
    function automatic logic [1:0] nz_of(input logic [7:0] v);
        return {v[7], (v == 8'h00)};
    endfunction

    // PC increment wraps naturally at the address width
    assign pc_inc_s   = pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    // High address bits beyond ADDR_WIDTH are simply dropped
    assign abs_full_s = {data, adl_r};
    assign abs_s      = abs_full_s[ADDR_WIDTH-1:0];
    assign sum_s      = {1'b0, a_r} + {1'b0, data} + {8'h00, c_r};

    // Next-state and datapath update; everything holds unless a state says otherwise
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        addr_s  = addr_r;
        rw_s    = rw_r;
        a_s     = a_r;
        n_s     = n_r;
        z_s     = z_r;
        c_s     = c_r;
        ir_s    = ir_r;
        adl_s   = adl_r;
        wdata_s = wdata_r;
        case (state_r)
            FETCH: begin
                ir_s    = data;
                pc_s    = pc_inc_s;
                addr_s  = pc_inc_s;
                state_s = DECODE;
            end
            DECODE: begin
                case (ir_r)
                    OP_LDA_IMM: begin
                        a_s        = data;
                        {n_s, z_s} = nz_of(data);
                        pc_s       = pc_inc_s;
                        addr_s     = pc_inc_s;
                        state_s    = FETCH;
                    end
                    OP_ADC_IMM: begin
                        {c_s, a_s} = sum_s;
                        {n_s, z_s} = nz_of(sum_s[7:0]);
                        pc_s       = pc_inc_s;
                        addr_s     = pc_inc_s;
                        state_s    = FETCH;
                    end
                    // Single-byte opcodes: the operand read was a dummy, re-fetch from PC
                    OP_NOP: begin
                        addr_s  = pc_r;
                        state_s = FETCH;
                    end
                    OP_CLC: begin
                        c_s     = 1'b0;
                        addr_s  = pc_r;
                        state_s = FETCH;
                    end
                    OP_SEC: begin
                        c_s     = 1'b1;
                        addr_s  = pc_r;
                        state_s = FETCH;
                    end
                    OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: begin
                        adl_s   = data;
                        pc_s    = pc_inc_s;
                        addr_s  = pc_inc_s;
                        state_s = ADDR_HI;
                    end
                    default: begin
                        state_s = HALT;
                    end
                endcase
            end
            ADDR_HI: begin
                case (ir_r)
                    OP_JMP_ABS: begin
                        pc_s    = abs_s;
                        addr_s  = abs_s;
                        state_s = FETCH;
                    end
                    OP_LDA_ABS: begin
                        pc_s    = pc_inc_s;
                        addr_s  = abs_s;
                        state_s = MEM_RD;
                    end
                    OP_STA_ABS: begin
                        pc_s    = pc_inc_s;
                        addr_s  = abs_s;
                        rw_s    = 1'b0;
                        wdata_s = a_r;
                        state_s = MEM_WR;
                    end
                    default: begin
                        state_s = HALT;
                    end
                endcase
            end
            MEM_RD: begin
                a_s        = data;
                {n_s, z_s} = nz_of(data);
                addr_s     = pc_r;
                state_s    = FETCH;
            end
            MEM_WR: begin
                rw_s    = 1'b1;
                addr_s  = pc_r;
                state_s = FETCH;
            end
            HALT: begin
                rw_s    = 1'b1;
                state_s = HALT;
            end
            default: begin
                rw_s    = 1'b1;
                state_s = HALT;
            end
        endcase
    end

    // State and datapath registers; reset releases the bus without waiting for clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            rw_r    <= 1'b1;
            a_r     <= 8'h00;
            n_r     <= 1'b0;
            z_r     <= 1'b0;
            c_r     <= 1'b0;
            ir_r    <= 8'h00;
            adl_r   <= 8'h00;
            wdata_r <= 8'h00;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            addr_r  <= addr_s;
            rw_r    <= rw_s;
            a_r     <= a_s;
            n_r     <= n_s;
            z_r     <= z_s;
            c_r     <= c_s;
            ir_r    <= ir_s;
            adl_r   <= adl_s;
            wdata_r <= wdata_s;
        end
    end

    // rw_r is low only in MEM_WR, so the bus is driven in no other state
    assign data   = rw_r ? 8'hzz : wdata_r;
    assign addr   = addr_r;
    assign rw     = rw_r;
    assign halted = (state_r == HALT);
    assign acc    = a_r;
    assign flags  = {n_r, z_r, c_r};

endmodule

// File: tb/tb_cpu6502_core.sv
// Directed bench for cpu6502_core: a 16-bit core and an 8-bit wrapping core,
// each with a combinational memory model on its data bus.
module tb_cpu6502_core;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0;
    logic [15:0] addr0;
    wire  [7:0]  data0;
    logic        rw0, halted0;
    logic [7:0]  acc0;
    logic [2:0]  flags0;

    logic        reset8;
    logic [7:0]  addr8;
    wire  [7:0]  data8;
    logic        rw8, halted8;
    logic [7:0]  acc8;
    logic [2:0]  flags8;

    logic [7:0]  mem0 [0:65535];
    logic [7:0]  mem8 [0:255];

    int total = 0;
    int bad   = 0;

    assign data0 = rw0 ? mem0[addr0] : 8'hzz;
    assign data8 = rw8 ? mem8[addr8] : 8'hzz;

    cpu6502_core #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut0 (
        .clk(clk), .reset(reset0), .addr(addr0), .data(data0),
        .rw(rw0), .halted(halted0), .acc(acc0), .flags(flags0)
    );

    cpu6502_core #(.ADDR_WIDTH(8), .RESET_PC(8'hFF)) dut8 (
        .clk(clk), .reset(reset8), .addr(addr8), .data(data8),
        .rw(rw8), .halted(halted8), .acc(acc8), .flags(flags8)
    );

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mem0();
        for (int i = 0; i < 65536; i++) mem0[i] = 8'h00;
    endtask

    task automatic release0();
        @(negedge clk);
        reset0 = 1'b0;
    endtask

    task automatic test_reset();
        reset0 = 1'b1;
        reset8 = 1'b1;
        #1;
        total++; if (addr0 !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=%h", addr0, 16'h0000); end
        total++; if (rw0 !== 1'b1) begin bad++; $display("FAIL reset_rw got=%b want=1", rw0); end
        total++; if (halted0 !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted0); end
        total++; if (acc0 !== 8'h00) begin bad++; $display("FAIL reset_acc got=%h want=00", acc0); end
        total++; if (flags0 !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", flags0); end
        total++; if (addr8 !== 8'hFF) begin bad++; $display("FAIL reset_addr8 got=%h want=ff", addr8); end
    endtask

    task automatic test_lda_adc();
        reset0 = 1'b1;
        clear_mem0();
        mem0[0] = 8'hA9; mem0[1] = 8'hF0; mem0[2] = 8'h69; mem0[3] = 8'h20;
        release0();
        run(2);
        total++; if (acc0 !== 8'hF0) begin bad++; $display("FAIL lda_imm_acc got=%h want=f0", acc0); end
        total++; if (flags0 !== 3'b100) begin bad++; $display("FAIL lda_imm_flags got=%b want=100", flags0); end
        total++; if (addr0 !== 16'h0002) begin bad++; $display("FAIL lda_imm_addr got=%h want=0002", addr0); end
        run(2);
        total++; if (acc0 !== 8'h10) begin bad++; $display("FAIL adc_acc got=%h want=10", acc0); end
        total++; if (flags0 !== 3'b001) begin bad++; $display("FAIL adc_flags got=%b want=001", flags0); end
        total++; if (addr0 !== 16'h0004) begin bad++; $display("FAIL adc_addr got=%h want=0004", addr0); end
    endtask

    task automatic test_lda_sta();
        reset0 = 1'b1;
        clear_mem0();
        mem0[0] = 8'hA9; mem0[1] = 8'h00; mem0[2] = 8'h8D;
        mem0[3] = 8'h34; mem0[4] = 8'h12; mem0[5] = 8'hEA;
        mem0[16'h1234] = 8'h5A;
        release0();
        run(2);
        total++; if (flags0 !== 3'b010) begin bad++; $display("FAIL lda_zero_flags got=%b want=010", flags0); end
        run(3);
        total++; if (addr0 !== 16'h1234) begin bad++; $display("FAIL sta_addr got=%h want=1234", addr0); end
        total++; if (rw0 !== 1'b0) begin bad++; $display("FAIL sta_rw got=%b want=0", rw0); end
        total++; if (data0 !== 8'h00) begin bad++; $display("FAIL sta_data got=%h want=00", data0); end
        total++; if (acc0 !== 8'h00) begin bad++; $display("FAIL sta_acc got=%h want=00", acc0); end
        run(1);
        total++; if (rw0 !== 1'b1) begin bad++; $display("FAIL sta_after_rw got=%b want=1", rw0); end
        total++; if (addr0 !== 16'h0005) begin bad++; $display("FAIL sta_after_addr got=%h want=0005", addr0); end
    endtask

    task automatic test_jmp_lda_abs();
        reset0 = 1'b1;
        clear_mem0();
        mem0[0] = 8'h4C; mem0[1] = 8'h00; mem0[2] = 8'h80;
        mem0[16'h8000] = 8'hAD; mem0[16'h8001] = 8'h10; mem0[16'h8002] = 8'h00;
        mem0[16'h0010] = 8'h81;
        release0();
        run(3);
        total++; if (addr0 !== 16'h8000) begin bad++; $display("FAIL jmp_addr got=%h want=8000", addr0); end
        run(3);
        total++; if (addr0 !== 16'h0010) begin bad++; $display("FAIL lda_abs_operand_addr got=%h want=0010", addr0); end
        run(1);
        total++; if (acc0 !== 8'h81) begin bad++; $display("FAIL lda_abs_acc got=%h want=81", acc0); end
        total++; if (flags0 !== 3'b100) begin bad++; $display("FAIL lda_abs_flags got=%b want=100", flags0); end
        total++; if (addr0 !== 16'h8003) begin bad++; $display("FAIL lda_abs_resume got=%h want=8003", addr0); end
    endtask

    task automatic test_flags_carry();
        // SEC, LDA #80 (carry kept), CLC
        reset0 = 1'b1;
        clear_mem0();
        mem0[0] = 8'h38; mem0[1] = 8'hA9; mem0[2] = 8'h80; mem0[3] = 8'h18; mem0[4] = 8'hEA;
        release0();
        run(2);
        total++; if (addr0 !== 16'h0001) begin bad++; $display("FAIL sec_addr got=%h want=0001", addr0); end
        run(2);
        total++; if (flags0 !== 3'b101) begin bad++; $display("FAIL lda_keeps_c got=%b want=101", flags0); end
        run(2);
        total++; if (flags0 !== 3'b100) begin bad++; $display("FAIL clc_flags got=%b want=100", flags0); end
    endtask

    task automatic test_illegal_halt();
        reset0 = 1'b1;
        clear_mem0();
        mem0[0] = 8'h38; mem0[1] = 8'h02;
        release0();
        run(2);
        total++; if (flags0[0] !== 1'b1) begin bad++; $display("FAIL halt_sec_c got=%b want=1", flags0[0]); end
        run(2);
        total++; if (halted0 !== 1'b1) begin bad++; $display("FAIL halt_entered got=%b want=1", halted0); end
        for (int i = 0; i < 12; i++) begin
            run(1);
            total++;
            if (addr0 !== 16'h0002 || rw0 !== 1'b1 || halted0 !== 1'b1) begin
                bad++;
                $display("FAIL halt_hold cyc=%0d got addr=%h rw=%b halted=%b want addr=0002 rw=1 halted=1", i, addr0, rw0, halted0);
            end
        end
        reset0 = 1'b1;
        #1;
        total++; if (addr0 !== 16'h0000) begin bad++; $display("FAIL halt_reset_addr got=%h want=0000", addr0); end
        total++; if (halted0 !== 1'b0) begin bad++; $display("FAIL halt_reset_halted got=%b want=0", halted0); end
    endtask

    task automatic test_wrap_and_async_reset();
        for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
        mem8[8'hFF] = 8'hA9; mem8[8'h00] = 8'h55;
        mem8[8'h01] = 8'h8D; mem8[8'h02] = 8'h10; mem8[8'h03] = 8'hAB;
        mem8[8'h10] = 8'h77;
        @(negedge clk);
        reset8 = 1'b0;
        run(1);
        total++; if (addr8 !== 8'h00) begin bad++; $display("FAIL wrap_operand_addr got=%h want=00", addr8); end
        run(1);
        total++; if (acc8 !== 8'h55) begin bad++; $display("FAIL wrap_acc got=%h want=55", acc8); end
        total++; if (addr8 !== 8'h01) begin bad++; $display("FAIL wrap_next_fetch got=%h want=01", addr8); end
        run(3);
        total++; if (addr8 !== 8'h10) begin bad++; $display("FAIL trunc_sta_addr got=%h want=10", addr8); end
        total++; if (rw8 !== 1'b0 || data8 !== 8'h55) begin bad++; $display("FAIL trunc_sta_bus got rw=%b data=%h want rw=0 data=55", rw8, data8); end
        #1;
        reset8 = 1'b1;
        #1;
        total++; if (rw8 !== 1'b1) begin bad++; $display("FAIL async_reset_rw got=%b want=1", rw8); end
        total++; if (addr8 !== 8'hFF) begin bad++; $display("FAIL async_reset_addr got=%h want=ff", addr8); end
        total++; if (data8 !== 8'hA9) begin bad++; $display("FAIL async_reset_bus got=%h want=a9", data8); end
    endtask

    initial begin
        reset0 = 1'b1;
        reset8 = 1'b1;
        test_reset();
        test_lda_adc();
        test_lda_sta();
        test_jmp_lda_abs();
        test_flags_carry();
        test_illegal_halt();
        test_wrap_and_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
